adc_spi_sampler: RTL and testbench
==================================

// Module: adc_spi_sampler
// PURPOSE
//  Periodically triggers a conversion on the 16-bit two's-complement SPI ADC that reads the IR
//  range sensor, and shifts the result in. Presents the latest sample as raw_adc_data, which feeds
//  the distance lookup stage directly. Emits a 1-cycle sample_valid strobe on each new word.
// PARAMETERS
//  CLK_DIV        4        clk cycles per SCLK half-period (>=2)
//  SAMPLE_PERIOD  100000   clk cycles between conversion triggers (1 kHz @ 100 MHz)
//  CS_SETUP       2        clk cycles from cs_n fall to first SCLK rise
//  CS_HOLD        2        clk cycles cs_n held high after last SCLK fall, before next start
//  AVG_LOG2       2        log2 of averaging depth (used only with ADC_AVG_EN)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  enable        in   1   1 = periodic sampling runs
//  adc_miso      in   1   ADC serial data, MSB first, changes on SCLK falling edge
//  adc_sclk      out  1   SPI clock, idles low (CPOL=0, CPHA=0)
//  adc_cs_n      out  1   ADC chip select, active low
//  raw_adc_data  out  16  signed; last completed (or averaged) sample
//  sample_valid  out  1   1-cycle strobe when raw_adc_data updates
//  busy          out  1   high from IDLE exit until return to IDLE
//  overrun       out  1   1-cycle strobe when a trigger tick lands while busy
// BEHAVIOUR
//  Reset (async, immediate, also mid-transfer):
//   - Outputs: cs_n=1, sclk=0, raw_adc_data=0, sample_valid=0, busy=0, overrun=0.
//   - State: timer=0, bit counter=0, accumulator=0, FSM=IDLE.
//  Timer: counts 0..SAMPLE_PERIOD-1 while enable=1, then wraps; tick at count SAMPLE_PERIOD-1.
//   - enable=0 clears the timer to 0 and holds it.
//   - First tick comes SAMPLE_PERIOD cycles after enable rises.
//  FSM states:
//   - IDLE: a tick moves to SETUP; cs_n drops on the next cycle.
//   - SETUP: holds cs_n low for CS_SETUP cycles, then goes to SHIFT.
//   - SHIFT: 16 SCLK periods of 2*CLK_DIV cycles each, sclk low half first. In the clk cycle
//     where sclk rises, adc_miso is shifted into the shift register LSB (shift left). After the
//     16th falling edge, goes to HOLD.
//   - HOLD: cs_n=1 for CS_HOLD cycles, then goes to DONE.
//   - DONE: 1 cycle; raw_adc_data loads, sample_valid=1, then returns to IDLE.
//  Latency, tick to sample_valid: 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + 1 cycles
//  (defaults: 134 cycles).
//  Tick while FSM != IDLE: the tick is dropped, overrun pulses for 1 cycle, and the transfer
//  in flight is unaffected.
//  enable falling mid-transfer: the current transfer completes and reports normally; no new
//  tick follows.
//  The bit counter is 5 bits and never wraps past 16; the shift register is exactly 16 bits.
//  Sample word: bit 15 is the sign bit, with no conversion. 0x8000 and 0x7FFF pass through as-is.
//  busy=1 in SETUP, SHIFT, HOLD and DONE.
// CONFIGURATION
//  ADC_AVG_EN defined:
//   - Each completed word is added, sign-extended, to a (16+AVG_LOG2)-bit signed accumulator.
//   - After 2**AVG_LOG2 words, raw_adc_data = accumulator >>> AVG_LOG2 (arithmetic, floor).
//     sample_valid pulses on that DONE only, and the accumulator then clears.
//   - enable=0 also clears the accumulator and the word count.
//  ADC_AVG_EN undefined:
//   - Every DONE updates raw_adc_data and pulses sample_valid.
//   - No accumulator logic is generated; AVG_LOG2 is ignored.
// STRUCTURE
//  Package adc_pkg:
//   - ADC_WORD_W=16.
//   - typedef enum adc_state_t {IDLE, SETUP, SHIFT, HOLD, DONE}.
//   - typedef logic signed [ADC_WORD_W-1:0] adc_word_t, shared with the distance lookup stage.
//  Sub-module adc_sclk_gen:
//   - Divider producing sclk, a rise_stb and a fall_stb.
//   - Enabled only in SHIFT; sclk is forced low otherwise.
//  Top level: timer, FSM, shift register, optional averager.
// TESTING
//  1. Defaults, enable=1, ADC model returns 0x1234 -> first sample_valid at cycle 100000+134
//     after enable; raw_adc_data=0x1234; cs_n low for exactly 16 SCLK periods.
//  2. Model returns 0x8000, then 0x7FFF, then 0xFFFF -> raw_adc_data=-32768, then 32767,
//     then -1, each with a 1-cycle sample_valid.
//  3. SAMPLE_PERIOD=100 with a transfer of 134 cycles -> overrun pulses once per dropped tick;
//     no transfer is corrupted or started early.
//  4. Assert reset during bit 7 of SHIFT -> same cycle: cs_n=1, sclk=0, busy=0; raw_adc_data=0;
//     after reset releases, the next full transfer is correct.
//  5. Drop enable mid-SHIFT -> that sample still completes with sample_valid; no further
//     cs_n activity while enable=0.
//  6. ADC_AVG_EN, AVG_LOG2=2, words 100, 101, 102, 104 -> a single sample_valid after the
//     4th word with raw_adc_data=101. Words -1, -2, -2, -2 -> raw_adc_data=-2.

Source files
------------

// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg: shared types and constants for the IR-sensor SPI ADC sampler.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_pkg;

   localparam int ADC_WORD_W = 16;
   localparam int ADC_CNT_W  = 5;
   localparam logic [ADC_CNT_W-1:0] ADC_BITS = ADC_CNT_W'(ADC_WORD_W);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } adc_state_t;

   typedef logic signed [ADC_WORD_W-1:0] adc_word_t;

endpackage

`default_nettype wire

// File: rtl/adc_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen: SPI clock divider (CPOL=0), low half first, with edge strobes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_cnt;
   logic             r_sclk;
   logic             w_edge;

   // Strobes mark the clk cycle whose closing edge toggles sclk.
   assign w_edge     = i_en && (r_cnt == C_DIV_LAST);
   assign o_rise_stb = w_edge && !r_sclk;
   assign o_fall_stb = w_edge && r_sclk;
   assign o_sclk     = r_sclk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_edge) begin
         r_cnt  <= '0;
         r_sclk <= !r_sclk;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/adc_spi_sampler.sv
// ---------------------------------------------------------------------------
// adc_spi_sampler: periodic 16-bit SPI ADC reader; define ADC_AVG_EN to
// publish the floor-average of every 2**AVG_LOG2 words.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_spi_sampler
   import adc_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 100000,
   parameter int CS_SETUP      = 2,
   parameter int CS_HOLD       = 2,
   parameter int AVG_LOG2      = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      i_enable,
   input  logic      i_adc_miso,
   output logic      o_adc_sclk,
   output logic      o_adc_cs_n,
   output adc_word_t o_raw_adc_data,
   output logic      o_sample_valid,
   output logic      o_busy,
   output logic      o_overrun
);

   localparam int TMR_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [TMR_W-1:0] C_TMR_LAST   = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [PH_W-1:0]  C_SETUP_LAST = PH_W'(CS_SETUP - 1);
   localparam logic [PH_W-1:0]  C_HOLD_LAST  = PH_W'(CS_HOLD - 1);

   adc_state_t           r_state, w_next_state;
   logic [TMR_W-1:0]     r_timer;
   logic [PH_W-1:0]      r_phase;
   logic [ADC_CNT_W-1:0] r_bit_cnt;
   logic [ADC_WORD_W-1:0] r_shift;
   logic                 r_cs_n, r_busy, r_overrun, r_valid;
   adc_word_t            r_raw;
   logic                 w_tick, w_done, w_rise_stb, w_fall_stb, w_sclk;

   assign w_tick = i_enable && (r_timer == C_TMR_LAST);
   assign w_done = (r_state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    r_timer <= '0;
      else if (!i_enable || w_tick) r_timer <= '0;
      else                          r_timer <= r_timer + 1'b1;
   end

   adc_sclk_gen #(
      .CLK_DIV    (CLK_DIV)
   ) u_sclk_gen (
      .clk        (clk),
      .reset      (reset),
      .i_en       (r_state == SHIFT),
      .o_sclk     (w_sclk),
      .o_rise_stb (w_rise_stb),
      .o_fall_stb (w_fall_stb)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_tick) w_next_state = SETUP;
         SETUP:   if (r_phase == C_SETUP_LAST) w_next_state = SHIFT;
         SHIFT:   if (w_fall_stb && (r_bit_cnt == ADC_BITS)) w_next_state = HOLD;
         HOLD:    if (r_phase == C_HOLD_LAST) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Phase counter times SETUP/HOLD; restarts on every state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase   <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_phase <= (w_next_state == r_state) ? r_phase + 1'b1 : '0;
         if (r_state != SHIFT) begin
            r_bit_cnt <= '0;
         end else if (w_rise_stb) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {r_shift[ADC_WORD_W-2:0], i_adc_miso};
         end
      end
   end

   // Strobes and pin levels are registered from the next state to stay glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_cs_n    <= !((w_next_state == SETUP) || (w_next_state == SHIFT));
         r_busy    <= (w_next_state != IDLE);
         r_overrun <= w_tick && (r_state != IDLE);
      end
   end

`ifdef ADC_AVG_EN
   localparam int ACC_W = ADC_WORD_W + AVG_LOG2;

   logic signed [ACC_W-1:0] r_acc, w_sum, w_avg;
   logic [AVG_LOG2-1:0]     r_avg_cnt;

   assign w_sum = r_acc + {{AVG_LOG2{r_shift[ADC_WORD_W-1]}}, r_shift};
   assign w_avg = w_sum >>> AVG_LOG2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_avg_cnt <= '0;
         r_raw     <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!i_enable) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
         end else if (w_done) begin
            if (&r_avg_cnt) begin
               r_raw     <= w_avg[ADC_WORD_W-1:0];
               r_valid   <= 1'b1;
               r_acc     <= '0;
               r_avg_cnt <= '0;
            end else begin
               r_acc     <= w_sum;
               r_avg_cnt <= r_avg_cnt + 1'b1;
            end
         end
      end
   end
`else
   if (AVG_LOG2 >= 0) begin : g_direct
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_raw   <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= w_done;
            if (w_done) r_raw <= r_shift;
         end
      end
   end
`endif

   assign o_adc_sclk     = w_sclk;
   assign o_adc_cs_n     = r_cs_n;
   assign o_raw_adc_data = r_raw;
   assign o_sample_valid = r_valid;
   assign o_busy         = r_busy;
   assign o_overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_sampler: randomized bench with a cycle-level reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_spi_sampler;
   import adc_pkg::*;

   localparam int CLK_DIV  = 4;
   localparam int SP       = 100;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int AVG_LOG2 = 2;
   localparam int XFER     = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD + 1;
   localparam int CS_LOW   = CS_SETUP + 32 * CLK_DIV;

   logic      clk = 1'b0;
   logic      reset, enable, miso;
   logic      sclk, cs_n, valid, busy, ovr;
   adc_word_t raw;

   always #5 clk = ~clk;

   adc_spi_sampler #(
      .CLK_DIV        (CLK_DIV),
      .SAMPLE_PERIOD  (SP),
      .CS_SETUP       (CS_SETUP),
      .CS_HOLD        (CS_HOLD),
      .AVG_LOG2       (AVG_LOG2)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .i_enable       (enable),
      .i_adc_miso     (miso),
      .o_adc_sclk     (sclk),
      .o_adc_cs_n     (cs_n),
      .o_raw_adc_data (raw),
      .o_sample_valid (valid),
      .o_busy         (busy),
      .o_overrun      (ovr)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ADC model: words presented MSB first, next bit after each sclk fall.
   logic [15:0] dq[$];
   logic [15:0] words[$];
   logic [15:0] cur = '0;
   int          bidx = 15, nrise = 0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b0;

   always @(posedge clk) begin
      #1;
      if (prev_cs && !cs_n) begin
         cur = (dq.size() != 0) ? dq.pop_front() : 16'($urandom);
         words.push_back(cur);
         bidx  = 15;
         miso  = cur[bidx];
         nrise = 0;
      end else if (!cs_n && prev_sclk && !sclk) begin
         if (bidx > 0) bidx--;
         miso = cur[bidx];
      end
      if (!cs_n && !prev_sclk && sclk) nrise++;
      if (!prev_cs && cs_n && !reset) chk("sclk_periods", nrise, 16);
      prev_cs   = cs_n;
      prev_sclk = sclk;
   end

`ifdef ADC_AVG_EN
   function automatic int floor_avg(input int s);
      int n = 1 << AVG_LOG2;
      int q = s / n;
      if ((s % n != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction
`endif

   // Reference model: transfer windows derived from tick times and the fixed latency.
   int          cyc = 0, run = 0, start = -1000, rd = 0;
   int          asum = 0, acnt = 0;
   logic        m_valid = 1'b0, m_ovr = 1'b0;
   logic [15:0] m_data = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         run = 0; start = -1000; rd = words.size();
         asum = 0; acnt = 0;
         m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
      end else begin
         int w;
         cyc++;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         if (cyc == start + XFER - 1) begin
            w = (rd < words.size()) ? int'($signed(words[rd])) : 0;
            rd++;
`ifdef ADC_AVG_EN
            if (enable) begin
               asum += w;
               acnt++;
               if (acnt == (1 << AVG_LOG2)) begin
                  m_data  = 16'(floor_avg(asum));
                  m_valid = 1'b1;
                  asum = 0; acnt = 0;
               end
            end
`else
            m_data  = 16'(w);
            m_valid = 1'b1;
`endif
         end
`ifdef ADC_AVG_EN
         if (!enable) begin asum = 0; acnt = 0; end
`endif
         if (enable) begin
            if (run % SP == SP - 1) begin
               if (cyc >= start + XFER) start = cyc;
               else                     m_ovr = 1'b1;
            end
            run++;
         end else begin
            run = 0;
         end
      end
   end

   always @(negedge clk) begin
      logic e_busy, e_cs_n;
      e_busy = (cyc >= start) && (cyc <= start + XFER - 2);
      e_cs_n = !((cyc >= start) && (cyc <= start + CS_LOW - 1));
      chk($sformatf("cycle%0d", cyc), {busy, cs_n, valid, ovr, raw},
          {e_busy, e_cs_n, m_valid, m_ovr, m_data});
   end

   task automatic wait_cs_low();
      int n = 0;
      while (cs_n !== 1'b0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cs_wait", {31'd0, cs_n === 1'b0}, 32'd1);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      miso   = 1'b0;
      dq = '{16'd100, 16'd101, 16'd102, 16'd104, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE,
             16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      repeat (1500) @(negedge clk);

      // Reset mid-SHIFT, inside bit 7.
      wait_cs_low();
      repeat (CS_SETUP + 7 * 2 * CLK_DIV + CLK_DIV) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_raw", {16'd0, raw}, 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (800) @(negedge clk);

      // Drop enable mid-transfer, then stay disabled.
      wait_cs_low();
      repeat (40) @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (500) @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         enable = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(50, 400)) @(negedge clk);
      end
      enable = 1'b1;
      repeat (600) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
